usb_page_streamer: RTL and testbench
====================================

Name: usb_page_streamer

Overview:
- Downstream consumer of the sdram_to_usb page buffer's read side, in the USB clock domain.
- Waits for a committed 64-byte page (rd_empty low) and reads it byte-by-byte through the buffer's synchronous read port.
- Presents the bytes as a valid/ready stream with a last flag to the bulk-IN endpoint transmitter.
- After the final byte is accepted, pulses rd_pull to release the page back to the buffer.

Parameters:
- ADDR_W, 6, byte address width of one page; page length is 2^ADDR_W bytes.
- CNT_W, 16, width of the released-page counter.

Ports:
- clk  in  1  USB-side clock; same net as the buffer's rd_clk.
- rst_n  in  1  Reset. Synchronous, active-low.
- en  in  1  Enables starting new pages. A page already in progress always completes.
- rd_empty  in  1  High when the buffer holds no committed page.
- rd_addr  out  ADDR_W  Byte address to the buffer read port.
- rd_data  in  8  Buffer read data, valid one clk after rd_addr is presented (registered RAM).
- rd_pull  out  1  One-cycle pulse that releases the current page.
- tx_data  out  8  Stream byte.
- tx_valid  out  1  tx_data holds a valid byte.
- tx_last  out  1  Qualifies the final byte of a page (meaningful only with tx_valid).
- tx_ready  in  1  Sink accepts the byte. A handshake occurs when tx_valid and tx_ready are both high on a rising edge.
- busy  out  1  High in any state other than IDLE.
- page_count  out  CNT_W  Number of pages released; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, rd_addr=0, rd_pull=0, tx_valid=0, tx_last=0, tx_data=0, busy=0, page_count=0.
  - Skid storage is emptied and any in-flight read is discarded.
  - Reset mid-page does not release the page (rd_pull is never asserted); the page is re-sent from byte 0 after reset.
- States: IDLE -> STREAM -> RELEASE -> SETTLE -> IDLE.
- IDLE:
  - rd_addr=0.
  - At an edge with en=1 and rd_empty=0, go to STREAM.
  - en=0 or rd_empty=1 keeps IDLE.
- STREAM:
  - Fetch address counter issues reads at addresses 0..2^ADDR_W-1.
  - A 2-entry output skid buffer absorbs the 1-cycle RAM latency.
  - A read is issued only when (skid occupancy + reads in flight) < 2, so backpressure never loses or duplicates a byte.
  - tx_valid rises no later than 3 cycles after the IDLE->STREAM edge.
  - With tx_ready held high, bytes 0..2^ADDR_W-1 are emitted on consecutive cycles with no bubbles.
  - While tx_valid=1 and tx_ready=0, tx_data, tx_last and tx_valid hold stable.
  - tx_valid never drops without a handshake.
  - tx_last=1 exactly with byte 2^ADDR_W-1.
  - rd_addr stops at 2^ADDR_W-1 after the last issue; there is no wrap into the next page.
  - The handshake of the last byte moves the state to RELEASE.
- RELEASE:
  - rd_pull=1 for exactly this one cycle.
  - tx_valid=0.
  - page_count increments by 1 (wrapping).
  - Next state: SETTLE.
- SETTLE:
  - One idle cycle so the buffer's rd_empty reflects the pull.
  - rd_empty is not sampled here.
  - Next state: IDLE.
- Back-to-back pages: the minimum spacing from a last-byte handshake to the next page's first byte handshake is 6 cycles with tx_ready=1.
- rd_empty rising during STREAM is ignored; the page was committed at entry.
- en falling during STREAM: the page finishes normally, then the block remains in IDLE.
- tx_ready may toggle arbitrarily, including high before tx_valid; acceptance is counted only on handshakes.

Test Plan:
- Single page, continuous ready:
  - Stimulus: buffer holds a page with byte k = k ^ 8'hA5; en=1; tx_ready=1.
  - Required: 64 consecutive handshakes carrying 8'hA5, 8'hA4, ... 8'h9A in order; tx_last only on the 64th; one rd_pull pulse one cycle later; page_count=1.
- Backpressure:
  - Stimulus: tx_ready pattern 1,0,0,1 repeating.
  - Required: 64 bytes in order with no duplicate or drop; tx_data stable across every stalled cycle; exactly one rd_pull.
- Three pages queued, tx_ready=1:
  - Required: 192 bytes; tx_last on handshakes 64, 128 and 192; three rd_pull pulses; page_count=3; every last-to-first-byte gap is 6 cycles.
- Reset mid-page:
  - Stimulus: rst_n low for 1 cycle after 20 handshakes.
  - Required: rd_pull never asserts; after reset the stream restarts at byte 0 and delivers 64 bytes; page_count=1.
- Enable gating:
  - Stimulus: en=0 with rd_empty=0 for 50 cycles.
  - Required: busy=0 and tx_valid=0 throughout.
  - Stimulus: en dropped at byte 10.
  - Required: the page completes (64 bytes plus rd_pull), then the block stays IDLE while the next page waits.
- Counter wrap:
  - Stimulus: CNT_W=2, 5 pages.
  - Required: page_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/usb_page_streamer_if.sv
// Read-port and bulk-IN stream signals between the page buffer, the streamer
// and the endpoint transmitter. master = streamer side.
interface usb_page_streamer_if #(
  parameter int ADDR_W = 6
) ();
  logic              rd_empty;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              rd_pull;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready;

  modport master (
    input  rd_empty, rd_data, tx_ready,
    output rd_addr, rd_pull, tx_data, tx_valid, tx_last
  );

  modport slave (
    output rd_empty, rd_data, tx_ready,
    input  rd_addr, rd_pull, tx_data, tx_valid, tx_last
  );
endinterface

// File: rtl/usb_page_streamer.sv
// Streams one committed page from the buffer's registered read port onto a
// valid/ready byte stream, then pulses rd_pull to hand the page back.
module usb_page_streamer #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  usb_page_streamer_if.master  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     page_count
);
  typedef enum logic [1:0] {IDLE, STREAM, RELEASE, SETTLE} state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] sent_cnt;
  logic              fetch_done;
  logic              inflight;
  logic              wptr, rptr;
  logic [1:0]        skid_cnt;
  logic [1:0][7:0]   skid_mem;
  logic              tx_valid;
  logic              pop;
  logic              issue;
  logic [2:0]        occ;

  // Occupancy counts the byte leaving this cycle as already gone, which is
  // what lets a 2-entry skid sustain one byte per cycle.
  always_comb begin
    tx_valid = (state == STREAM) && (skid_cnt != 2'd0);
    pop      = tx_valid && bus.tx_ready;
    occ      = {1'b0, skid_cnt} + {2'b0, inflight};
    issue    = (state == STREAM) && !fetch_done && (occ < (3'd2 + {2'b0, pop}));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en && !bus.rd_empty) state_nx = STREAM;
      STREAM:  if (pop && (sent_cnt == LAST)) state_nx = RELEASE;
      RELEASE: state_nx = SETTLE;
      SETTLE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_addr <= '0;
      fetch_done <= 1'b0;
      sent_cnt   <= '0;
      inflight   <= 1'b0;
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      skid_cnt   <= 2'd0;
      skid_mem   <= '0;
      page_count <= '0;
    end else begin
      inflight <= issue;
      if (state != STREAM) begin
        fetch_addr <= '0;
        fetch_done <= 1'b0;
        sent_cnt   <= '0;
      end else begin
        // Address parks on the last byte; no wrap into the next page.
        if (issue) begin
          if (fetch_addr == LAST) fetch_done <= 1'b1;
          else                    fetch_addr <= fetch_addr + ADDR_W'(1);
        end
        if (pop) sent_cnt <= sent_cnt + ADDR_W'(1);
      end
      if (inflight) begin
        skid_mem[wptr] <= bus.rd_data;
        wptr           <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      skid_cnt <= skid_cnt + {1'b0, inflight} - {1'b0, pop};
      if (state == RELEASE) page_count <= page_count + CNT_W'(1);
    end
  end

  assign bus.rd_addr  = fetch_addr;
  assign bus.rd_pull  = (state == RELEASE);
  assign bus.tx_valid = tx_valid;
  assign bus.tx_last  = tx_valid && (sent_cnt == LAST);
  assign bus.tx_data  = skid_mem[rptr];
  assign busy         = (state != IDLE);
endmodule

// File: tb/tb_usb_page_streamer.sv
// Randomized bench for usb_page_streamer: page-buffer model, ready driver and a
// per-cycle compare process against a transaction-level reference.
module tb_usb_page_streamer;
  logic clk, rst_n, en;
  logic [15:0] page_count;
  logic [1:0]  page_count_w;
  logic        busy, busy_w;

  usb_page_streamer_if #(.ADDR_W(6)) bus ();
  usb_page_streamer_if #(.ADDR_W(6)) bus_w ();

  usb_page_streamer #(.ADDR_W(6), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus), .busy(busy), .page_count(page_count));
  usb_page_streamer #(.ADDR_W(6), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus_w), .busy(busy_w), .page_count(page_count_w));

  int passes = 0, total = 0;
  int pages_added = 0, pages_pulled = 0;
  int mode = 0, pat_i = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] pg_byte(int p, int k);
    return 8'(k) ^ 8'hA5 ^ 8'(p * 59);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // Page buffer: registered read of the head page; a pull retires the head.
  assign bus.rd_empty   = (pages_added == pages_pulled);
  assign bus_w.rd_empty = (pages_added == pages_pulled);
  assign bus_w.tx_ready = bus.tx_ready;
  always @(posedge clk) begin
    bus.rd_data   <= pg_byte(pages_pulled, int'(bus.rd_addr));
    bus_w.rd_data <= pg_byte(pages_pulled, int'(bus_w.rd_addr));
    if (bus.rd_pull) pages_pulled <= pages_pulled + 1;
  end

  // Sink ready: 0 = always, 1 = 1,0,0,1 pattern, 2 = random.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        1:       bus.tx_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
        2:       bus.tx_ready = 1'($urandom_range(0, 1));
        default: bus.tx_ready = 1'b1;
      endcase
      pat_i++;
    end
  end

  // Reference: a page is a run of 64 handshakes; after the last comes one
  // release cycle and one settle cycle, then the block may start again.
  int cyc = 0, start_cyc = -10, last_cyc = -100, exact_from = 0;
  int exp_k = 0, m_page = 0, m_pcnt = 0, n_pull = 0, n_hs = 0, m_cool = 0;
  bit m_active = 0, rst_chk = 0, stall = 0, gap_exact = 0, rec = 0;
  logic [7:0] st_data;
  logic       st_last;
  logic [7:0] q_bytes[$];
  logic [1:0] wrap_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_active = 0; m_cool = 0; exp_k = 0; m_pcnt = 0;
      stall = 0; rst_chk = 1; last_cyc = -100;
    end else begin
      if (rst_chk) begin
        chk("rst_busy", busy, 0);
        chk("rst_valid", bus.tx_valid, 0);
        chk("rst_last", bus.tx_last, 0);
        chk("rst_data", bus.tx_data, 0);
        chk("rst_addr", bus.rd_addr, 0);
        chk("rst_count_w", page_count_w, 0);
        rst_chk = 0;
      end
      chk("busy", busy, m_active || m_cool > 0);
      chk("rd_pull", bus.rd_pull, m_cool == 2);
      chk("page_count", page_count, m_pcnt % 65536);
      chk("page_count_w", page_count_w, m_pcnt % 4);
      if (!m_active) chk("idle_valid", bus.tx_valid, 0);
      if (!m_active && m_cool == 0) chk("idle_addr", bus.rd_addr, 0);
      if (m_active && cyc == start_cyc + 3) chk("first_valid", bus.tx_valid, 1);
      if (stall) begin
        chk("stall_valid", bus.tx_valid, 1);
        chk("stall_data", bus.tx_data, st_data);
        chk("stall_last", bus.tx_last, st_last);
      end
      if (m_cool > 0) begin
        if (m_cool == 2) begin m_pcnt++; m_page++; n_pull++; end
        if (m_cool == 1 && rec) wrap_q.push_back(page_count_w);
        m_cool--;
      end else if (!m_active && en && !bus.rd_empty) begin
        m_active = 1;
        start_cyc = cyc;
      end
      if (bus.tx_valid) chk("tx_last", bus.tx_last, exp_k == 63);
      if (bus.tx_valid && bus.tx_ready) begin
        chk("tx_data", bus.tx_data, pg_byte(m_page, exp_k));
        q_bytes.push_back(bus.tx_data);
        n_hs++;
        if (exp_k == 0 && last_cyc >= 0) begin
          if (gap_exact && last_cyc >= exact_from) chk("gap_exact", cyc - last_cyc, 6);
          else chk("gap_min", (cyc - last_cyc) >= 6, 1);
        end
        if (exp_k == 63) begin
          last_cyc = cyc; m_active = 0; m_cool = 2; exp_k = 0;
        end else exp_k++;
      end
      stall   = bus.tx_valid && !bus.tx_ready;
      st_data = bus.tx_data;
      st_last = bus.tx_last;
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_pulls(int target, int budget);
    int n = 0;
    while (n_pull < target && n < budget) begin tick(1); n++; end
    chk("pull_timeout", n_pull >= target, 1);
  endtask

  task automatic wait_hs(int target, int budget);
    int n = 0;
    while (n_hs < target && n < budget) begin tick(1); n++; end
    chk("hs_timeout", n_hs >= target, 1);
  endtask

  initial begin
    int h0, p0;
    rst_n = 1'b0; en = 1'b0;
    tick(3); rst_n = 1'b1; tick(2);

    // single page, continuous ready
    h0 = n_hs; p0 = n_pull;
    en = 1'b1; pages_added++;
    wait_pulls(p0 + 1, 300); tick(3);
    chk("p1_count", n_hs - h0, 64);
    chk("p1_first", q_bytes[h0], 8'hA5);
    chk("p1_last", q_bytes[h0 + 63], 8'h9A);
    chk("p1_pages", page_count, 1);

    // backpressure 1,0,0,1
    mode = 1; h0 = n_hs; p0 = n_pull;
    pages_added++;
    wait_pulls(p0 + 1, 500); tick(3);
    chk("bp_count", n_hs - h0, 64);
    chk("bp_pulls", n_pull - p0, 1);

    // three pages back-to-back
    mode = 0; h0 = n_hs; p0 = n_pull;
    exact_from = cyc; gap_exact = 1;
    pages_added += 3;
    wait_pulls(p0 + 3, 800); tick(3);
    gap_exact = 0;
    chk("b2b_count", n_hs - h0, 192);
    chk("b2b_pages", page_count, 5);

    // reset mid-page with random ready
    mode = 2; h0 = n_hs; p0 = n_pull;
    pages_added++;
    wait_hs(h0 + 20, 400);
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    h0 = n_hs;
    wait_pulls(p0 + 1, 800); tick(3);
    chk("rst_count", n_hs - h0, 64);
    chk("rst_pages", page_count, 1);

    // enable gating
    mode = 0; en = 1'b0; pages_added++;
    tick(50);
    chk("gate_busy", busy, 0);
    h0 = n_hs; p0 = n_pull;
    en = 1'b1;
    wait_hs(h0 + 10, 100);
    en = 1'b0; pages_added++;
    wait_pulls(p0 + 1, 300); tick(40);
    chk("gate_count", n_hs - h0, 64);
    chk("gate_idle", busy, 0);
    en = 1'b1;
    wait_pulls(p0 + 2, 300); tick(3);
    chk("gate_pages", page_count, 3);

    // counter wrap on the 2-bit instance
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
    mode = 2; rec = 1; p0 = n_pull;
    pages_added += 5;
    wait_pulls(p0 + 5, 3000); tick(3);
    rec = 0;
    chk("wrap_n", wrap_q.size(), 5);
    if (wrap_q.size() == 5) begin
      chk("wrap_0", wrap_q[0], 1);
      chk("wrap_1", wrap_q[1], 2);
      chk("wrap_2", wrap_q[2], 3);
      chk("wrap_3", wrap_q[3], 0);
      chk("wrap_4", wrap_q[4], 1);
    end
    chk("wrap_pages", page_count, 5);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
